// File: rtl/gmii_rx_framer.sv
`default_nettype none
// ------------------------------------------------------------------------
// gmii_rx_framer: strips preamble/SFD, hides the FCS, flags CRC/length errors.
// Revision 1.0
// ------------------------------------------------------------------------

module gmii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        out_dv,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt
);

  localparam logic [7:0]  c_PREAMBLE    = 8'h55;
  localparam logic [7:0]  c_SFD         = 8'hD5;
  localparam logic [31:0] c_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] c_CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] c_CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] c_CNT_MAX     = 11'h7FF;
  localparam logic [10:0] c_MIN_LEN     = MIN_LEN[10:0];
  localparam logic [10:0] c_MAX_LEN     = MAX_LEN[10:0];
  localparam logic [10:0] c_FCS_PLUS1   = 11'd5;
  localparam logic [2:0]  c_PRE_MAX     = 3'd7;
  localparam logic [15:0] c_STAT_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ c_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      pre_cnt_q, pre_cnt_d;
  logic            post_rst_q, post_rst_d;
  logic [3:0][7:0] dline_q, dline_d;
  logic [7:0]      p_q, p_d;
  logic [10:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]     crc_q, crc_d;
  logic            sof_pend_q, sof_pend_d;
  logic            out_dv_q, out_dv_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eof_q, out_eof_d;
  logic            out_err_q, out_err_d;
  logic [15:0]     ok_cnt_q, ok_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic            w_ok_inc;
  logic            w_err_inc;
  logic            w_p_valid;
  logic            w_frame_bad;
  logic [31:0]     w_crc_next;

  assign w_crc_next  = crc32_byte(crc_q, gmii_rxd);
  // P holds a real payload byte once five bytes are in (four sit in the delay line).
  assign w_p_valid   = (byte_cnt_q >= c_FCS_PLUS1);
  assign w_frame_bad = (crc_q != c_CRC_RESIDUE) || (byte_cnt_q < c_MIN_LEN) ||
                       (byte_cnt_q > c_MAX_LEN);

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    post_rst_d = post_rst_q;
    dline_d    = dline_q;
    p_d        = p_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    sof_pend_d = sof_pend_q;
    out_dv_d   = 1'b0;
    out_data_d = 8'd0;
    out_sof_d  = 1'b0;
    out_eof_d  = 1'b0;
    out_err_d  = 1'b0;
    w_ok_inc   = 1'b0;
    w_err_inc  = 1'b0;

    // A frame already in flight when reset lifts must not be mistaken for a new one.
    if (!gmii_rx_dv) begin
      post_rst_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == c_PREAMBLE && !post_rst_q) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
        end else if (gmii_rxd == c_SFD) begin
          state_d    = S_DATA;
          byte_cnt_d = 11'd0;
          crc_d      = c_CRC_INIT;
          sof_pend_d = 1'b1;
        end else if (gmii_rxd == c_PREAMBLE && pre_cnt_q < c_PRE_MAX) begin
          pre_cnt_d = pre_cnt_q + 3'd1;
        end else begin
          state_d   = S_DROP;
          w_err_inc = 1'b1;
        end
      end

      S_DATA: begin
        if (gmii_rx_dv) begin
          dline_d = {dline_q[2:0], gmii_rxd};
          p_d     = dline_q[3];
          crc_d   = w_crc_next;
          if (byte_cnt_q != c_CNT_MAX) begin
            byte_cnt_d = byte_cnt_q + 11'd1;
          end
          if (w_p_valid) begin
            out_dv_d   = 1'b1;
            out_data_d = p_q;
            out_sof_d  = sof_pend_q;
            sof_pend_d = 1'b0;
          end
        end else begin
          state_d    = S_IDLE;
          sof_pend_d = 1'b0;
          if (w_p_valid) begin
            out_dv_d   = 1'b1;
            out_data_d = p_q;
            out_sof_d  = sof_pend_q;
            out_eof_d  = 1'b1;
            out_err_d  = w_frame_bad;
            w_ok_inc   = !w_frame_bad;
            w_err_inc  = w_frame_bad;
          end else begin
            w_err_inc = 1'b1;
          end
        end
      end

      S_DROP: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    ok_cnt_d  = (w_ok_inc && ok_cnt_q != c_STAT_MAX) ? ok_cnt_q + 16'd1 : ok_cnt_q;
    err_cnt_d = (w_err_inc && err_cnt_q != c_STAT_MAX) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= 3'd0;
      post_rst_q <= 1'b1;
      dline_q    <= '0;
      p_q        <= 8'd0;
      byte_cnt_q <= 11'd0;
      crc_q      <= c_CRC_INIT;
      sof_pend_q <= 1'b0;
      out_dv_q   <= 1'b0;
      out_data_q <= 8'd0;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
      out_err_q  <= 1'b0;
      ok_cnt_q   <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      post_rst_q <= post_rst_d;
      dline_q    <= dline_d;
      p_q        <= p_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      sof_pend_q <= sof_pend_d;
      out_dv_q   <= out_dv_d;
      out_data_q <= out_data_d;
      out_sof_q  <= out_sof_d;
      out_eof_q  <= out_eof_d;
      out_err_q  <= out_err_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_dv        = out_dv_q;
  assign out_data      = out_data_q;
  assign out_sof       = out_sof_q;
  assign out_eof       = out_eof_q;
  assign out_err       = out_err_q;
  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gmii_rx_framer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_gmii_rx_framer: directed frames with a queue-based output scoreboard.
// Revision 1.0
// ------------------------------------------------------------------------

module tb_gmii_rx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv  = 1'b0;
  logic [7:0]  rxd = 8'd0;
  logic        out_dv;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .gmii_rx_clk   (clk),
    .rst           (rst),
    .gmii_rx_dv    (dv),
    .gmii_rxd      (rxd),
    .out_dv        (out_dv),
    .out_data      (out_data),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .out_err       (out_err),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       err;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_first_cyc = 0;
  bit   lat_armed = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Monitor: pops one expected entry for every byte the DUT presents.
  exp_t e_mon;
  always @(negedge clk) begin
    if (out_dv) begin
      chk(exp_q.size() != 0, "unexpected_byte", out_data, 0);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        chk(out_data == e_mon.data, "out_data", out_data, e_mon.data);
        chk(out_sof == e_mon.sof, "out_sof", out_sof, e_mon.sof);
        chk(out_eof == e_mon.eof, "out_eof", out_eof, e_mon.eof);
        if (e_mon.eof) chk(out_err == e_mon.err, "out_err", out_err, e_mon.err);
        if (lat_armed && e_mon.sof) begin
          chk(cyc == exp_first_cyc, "first_byte_latency", cyc, exp_first_cyc);
          lat_armed = 1'b0;
        end
      end
    end else begin
      chk(!(out_sof || out_eof || out_err), "idle_flags", {out_sof, out_eof, out_err}, 0);
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  function automatic bq_t build(input int npay, input int seed, input bit flip);
    bq_t         q;
    logic [31:0] crc;
    logic [7:0]  d;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      d = 8'((i * 13 + seed) & 255);
      q.push_back(d);
      crc = crc_upd(crc, d);
    end
    crc = ~crc;
    if (flip) crc[0] = ~crc[0];
    q.push_back(crc[7:0]);
    q.push_back(crc[15:8]);
    q.push_back(crc[23:16]);
    q.push_back(crc[31:24]);
    return q;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    dv  = v;
    rxd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic preamble_sfd();
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
  endtask

  // Bytes after SFD are in b (FCS included); one dv=0 cycle follows as IPG.
  task automatic send_frame(input bq_t b, input bit exp_err, input bit arm);
    exp_t e;
    int   n;
    n = b.size();
    for (int i = 0; i < n - 4; i++) begin
      e.data = b[i];
      e.sof  = (i == 0);
      e.eof  = (i == n - 5);
      e.err  = exp_err;
      exp_q.push_back(e);
    end
    preamble_sfd();
    for (int i = 0; i < n; i++) begin
      if (arm && i == 0) begin
        exp_first_cyc = cyc + 6;
        lat_armed     = 1'b1;
      end
      drive(1'b1, b[i]);
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic bad_preamble();
    drive(1'b1, 8'h55);
    drive(1'b1, 8'hAA);
    drive(1'b0, 8'h00);
  endtask

  task automatic chk_cnt(input logic [15:0] ok_req, input logic [15:0] err_req);
    chk(frame_ok_cnt == ok_req, "frame_ok_cnt", frame_ok_cnt, ok_req);
    chk(frame_err_cnt == err_req, "frame_err_cnt", frame_err_cnt, err_req);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t  b;
    exp_t e;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 8'h00);
    chk(out_dv == 1'b0, "reset_out_dv", out_dv, 0);
    chk(out_data == 8'h00, "reset_out_data", out_data, 0);
    chk_cnt(16'd0, 16'd0);

    // Good 60-byte payload; first byte latency also checked.
    send_frame(build(60, 1, 1'b0), 1'b0, 1'b1);
    chk_cnt(16'd1, 16'd0);

    send_frame(build(60, 1, 1'b1), 1'b1, 1'b0);
    chk_cnt(16'd1, 16'd1);

    // 40-byte runt, 1530-byte giant, 1518-byte maximum.
    send_frame(build(36, 2, 1'b0), 1'b1, 1'b0);
    chk_cnt(16'd1, 16'd2);
    send_frame(build(1526, 3, 1'b0), 1'b1, 1'b0);
    chk_cnt(16'd1, 16'd3);
    send_frame(build(1514, 4, 1'b0), 1'b0, 1'b0);
    chk_cnt(16'd2, 16'd3);

    // Bad SFD, then a good frame after a single idle cycle.
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hAA);
    chk_cnt(16'd2, 16'd4);
    drive(1'b0, 8'h00);
    send_frame(build(60, 9, 1'b0), 1'b0, 1'b0);
    chk_cnt(16'd3, 16'd4);

    // Four bytes after SFD: nothing out. Five bytes: single sof+eof byte.
    b = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(b, 1'b1, 1'b0);
    chk_cnt(16'd3, 16'd5);
    send_frame(build(1, 7, 1'b0), 1'b1, 1'b0);
    chk_cnt(16'd3, 16'd6);

    // Reset at payload byte 20 while dv stays high; tail looks like a new frame.
    b = build(60, 5, 1'b0);
    for (int i = 0; i < 15; i++) begin
      e.data = b[i];
      e.sof  = (i == 0);
      e.eof  = 1'b0;
      e.err  = 1'b0;
      exp_q.push_back(e);
    end
    preamble_sfd();
    for (int i = 0; i < 20; i++) drive(1'b1, b[i]);
    rst = 1'b1;
    drive(1'b1, b[20]);
    rst = 1'b0;
    preamble_sfd();
    for (int i = 21; i < 41; i++) drive(1'b1, b[i]);
    drive(1'b0, 8'h00);
    chk_cnt(16'd0, 16'd0);
    send_frame(build(60, 11, 1'b0), 1'b0, 1'b0);
    chk_cnt(16'd1, 16'd0);

    // Saturation with preloaded statistics counters.
    force dut.err_cnt_q = 16'hFFFD;
    drive(1'b0, 8'h00);
    release dut.err_cnt_q;
    drive(1'b0, 8'h00);
    chk(frame_err_cnt == 16'hFFFD, "err_preload", frame_err_cnt, 16'hFFFD);
    bad_preamble();
    chk(frame_err_cnt == 16'hFFFE, "err_cnt_fffe", frame_err_cnt, 16'hFFFE);
    bad_preamble();
    chk(frame_err_cnt == 16'hFFFF, "err_cnt_ffff", frame_err_cnt, 16'hFFFF);
    bad_preamble();
    chk(frame_err_cnt == 16'hFFFF, "err_cnt_sat", frame_err_cnt, 16'hFFFF);

    force dut.ok_cnt_q = 16'hFFFE;
    drive(1'b0, 8'h00);
    release dut.ok_cnt_q;
    drive(1'b0, 8'h00);
    send_frame(build(60, 13, 1'b0), 1'b0, 1'b0);
    chk(frame_ok_cnt == 16'hFFFF, "ok_cnt_ffff", frame_ok_cnt, 16'hFFFF);
    send_frame(build(60, 17, 1'b0), 1'b0, 1'b0);
    chk(frame_ok_cnt == 16'hFFFF, "ok_cnt_sat", frame_ok_cnt, 16'hFFFF);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk(exp_q.size() == 0, "scoreboard_drain", exp_q.size(), 0);
    chk(lat_armed == 1'b0, "latency_seen", lat_armed, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gmii_rx_framer.md
GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum legal frame length in bytes, counted after SFD and including FCS.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum legal frame length in bytes, same counting as MIN_LEN.
REQ-003 SHALL use one clock and a synchronous active-high reset; there are no other clock domains.
REQ-004 gmii_rx_clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 gmii_rx_dv  in  1  GMII receive data valid.
REQ-007 gmii_rxd  in  8  GMII receive byte, including preamble, SFD and FCS.
REQ-008 out_dv  out  1  payload byte valid; feeds the gmii_to_axi input.
REQ-009 out_data  out  8  payload byte.
REQ-010 out_sof  out  1  first payload byte of a frame; asserted only when out_dv=1.
REQ-011 out_eof  out  1  last payload byte of a frame; asserted only when out_dv=1.
REQ-012 out_err  out  1  frame status; meaningful only when out_eof=1.
REQ-013 frame_ok_cnt  out  16  count of good frames, saturating.
REQ-014 frame_err_cnt  out  16  count of bad or dropped frames, saturating.

Function
REQ-015 SHALL implement an FSM with states IDLE, PREAMBLE, DATA and DROP.
REQ-016 IDLE transitions:
- dv=1 and rxd=0x55 -> PREAMBLE, preamble count=1.
- dv=1 and any other byte -> DROP.
- dv=0 -> stay in IDLE.
REQ-017 PREAMBLE transitions:
- rxd=0x55 with count<7 -> count+1.
- rxd=0xD5 -> DATA.
- 8th 0x55, or any other byte -> DROP, frame_err_cnt+1.
- dv=0 -> IDLE, no count change.
REQ-018 DROP: SHALL ignore all bytes and return to IDLE on the first cycle with dv=0; SHALL emit nothing.
REQ-019 DATA: every byte SHALL enter a 4-byte delay line and the CRC-32 engine.
- CRC-32: IEEE 802.3, reflected, initialised to 0xFFFFFFFF at SFD.
- Byte counter: 11 bits, saturating at 2047.
REQ-020 Byte leaving the delay line SHALL load pending register P; the previous P content SHALL be driven to out_* with out_dv=1 on the next edge.
REQ-021 The first emitted byte of a frame SHALL carry out_sof=1.
REQ-022 Latency: payload byte k sampled at edge e_k SHALL appear on out_* after edge e_(k+5); output is gapless, one byte per clock; there is no backpressure.
REQ-023 End of frame: dv=0 sampled in DATA SHALL emit P with out_eof=1; the 4 FCS bytes in the delay line SHALL be discarded; FSM -> IDLE.
REQ-024 out_err=1 at eof SHALL be set when any of these holds:
- CRC residue != 0xDEBB20E3;
- byte count < MIN_LEN;
- byte count > MAX_LEN.
REQ-025 At eof, frame_ok_cnt SHALL increment when out_err=0, otherwise frame_err_cnt SHALL increment; both counters saturate at 0xFFFF.
REQ-026 A frame with 4 or fewer bytes after SFD SHALL emit nothing and SHALL increment frame_err_cnt.
REQ-027 A frame with exactly 5 bytes after SFD SHALL emit one byte with out_sof=1 and out_eof=1 in the same cycle.
REQ-028 A frame with dv=1 for more than MAX_LEN bytes SHALL keep streaming and SHALL be flagged only at eof.
REQ-029 Back-to-back frames: the eof emission and the IDLE->PREAMBLE detection of the next frame SHALL occur independently; an IPG of one dv=0 cycle SHALL be sufficient.
REQ-030 out_sof, out_eof and out_err SHALL be 0 whenever out_dv=0.

Reset
REQ-031 rst=1 SHALL drive:
- FSM -> IDLE;
- out_dv, out_sof, out_eof, out_err, out_data -> 0;
- delay line, P and byte counter cleared;
- both statistics counters -> 0.
REQ-032 Reset mid-frame SHALL produce no eof for the aborted frame; if dv is still 1 after release, the remainder of that frame SHALL be handled through DROP and SHALL count as nothing.

Verification
REQ-033 7x0x55, 0xD5, 60 payload bytes, correct FCS -> 60 out bytes, sof on byte 0, eof on byte 59, out_err=0, frame_ok_cnt=1; first out_dv 5 clocks after first payload byte.
REQ-034 Same frame with one FCS bit flipped -> 60 bytes, out_err=1 at eof, frame_err_cnt=1, frame_ok_cnt unchanged.
REQ-035 40-byte runt with valid FCS -> 36 bytes, out_err=1; 1530-byte frame -> out_err=1; 1518-byte frame -> out_err=0.
REQ-036 Preamble followed by 0xAA instead of 0xD5 -> no out_dv, frame_err_cnt+1; next good frame after a 1-cycle gap is received correctly.
REQ-037 rst pulsed at payload byte 20 with dv held high -> no eof, counters 0, next frame good.
REQ-038 Drive 70000 bad frames, or preload the counter -> frame_err_cnt holds at 0xFFFF.
